// File: rtl/photon100_perm_if.sv
// Handshake bundle between the sponge absorb/squeeze controller and the PHOTON-100 permutation core.
interface photon100_perm_if;
    logic        in_valid;
    logic        in_ready;
    logic [99:0] in_state;
    logic        out_valid;
    logic        out_ready;
    logic [99:0] out_state;
    logic        busy;
    logic [3:0]  round_idx;

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy, round_idx
    );

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy, round_idx
    );
endinterface

// File: rtl/photon100_perm.sv
// Iterative PHOTON-80/20/16 permutation: 5x5 matrix of 4-bit cells, one full round
// (AddConstants, SubCells, ShiftRows, MixColumnsSerial) per clock.
module photon100_perm #(
    parameter int NUM_ROUNDS = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    photon100_perm_if.slave  bus
);
    typedef logic [3:0] cell_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

    function automatic cell_t rc(input logic [3:0] v);
        unique case (v)
            4'd0:    rc = 4'h1;
            4'd1:    rc = 4'h3;
            4'd2:    rc = 4'h7;
            4'd3:    rc = 4'hE;
            4'd4:    rc = 4'hD;
            4'd5:    rc = 4'hB;
            4'd6:    rc = 4'h6;
            4'd7:    rc = 4'hC;
            4'd8:    rc = 4'h9;
            4'd9:    rc = 4'h2;
            4'd10:   rc = 4'h5;
            4'd11:   rc = 4'hA;
            default: rc = 4'h0;
        endcase
    endfunction

    function automatic cell_t ic(input int i);
        unique case (i)
            1:       ic = 4'h1;
            2:       ic = 4'h3;
            3:       ic = 4'h6;
            4:       ic = 4'h4;
            default: ic = 4'h0;
        endcase
    endfunction

    function automatic cell_t sbox(input cell_t x);
        unique case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    // GF(2^4) mod x^4+x+1: doubling folds x^4 back in as x+1.
    function automatic cell_t mul2(input cell_t x);
        return {x[2:0], 1'b0} ^ {2'b00, x[3], x[3]};
    endfunction

    function automatic cell_t mul9(input cell_t x);
        return mul2(mul2(mul2(x))) ^ x;
    endfunction

    function automatic logic [99:0] photon_round(input logic [99:0] s, input logic [3:0] v);
        cell_t m   [5][5];
        cell_t row [5];
        cell_t col [5];
        cell_t t;
        logic [99:0] r;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                m[i][j] = s[(24 - 5*i - j)*4 +: 4];
        for (int i = 0; i < 5; i++)
            m[i][0] = m[i][0] ^ rc(v) ^ ic(i);
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                m[i][j] = sbox(m[i][j]);
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++)
                row[j] = m[i][(j + i) % 5];
            for (int j = 0; j < 5; j++)
                m[i][j] = row[j];
        end
        // Serial MixColumns: five shift-and-feedback steps per column.
        for (int j = 0; j < 5; j++) begin
            for (int k = 0; k < 5; k++)
                col[k] = m[k][j];
            for (int n = 0; n < 5; n++) begin
                t = col[0] ^ mul2(col[1]) ^ mul9(col[2]) ^ mul9(col[3]) ^ mul2(col[4]);
                for (int k = 0; k < 4; k++)
                    col[k] = col[k+1];
                col[4] = t;
            end
            for (int k = 0; k < 5; k++)
                m[k][j] = col[k];
        end
        r = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                r[(24 - 5*i - j)*4 +: 4] = m[i][j];
        return r;
    endfunction

    fsm_e        fsm_q;
    logic [99:0] state_q;
    logic [3:0]  rnd_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        busy_q;
    logic [99:0] round_d;

    assign round_d = photon_round(state_q, rnd_q);

    // NOTE: every register here uses <= so all next-state values are computed from the
    // pre-edge state; blocking assignments would let later statements see updated values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            rnd_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (fsm_q)
                IDLE: if (bus.in_valid) begin
                    state_q    <= bus.in_state;
                    rnd_q      <= '0;
                    fsm_q      <= RUN;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
                RUN: begin
                    state_q <= round_d;
                    if (rnd_q == LAST_RND) begin
                        fsm_q       <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    fsm_q       <= IDLE;
                    rnd_q       <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.round_idx = busy_q ? rnd_q : 4'd0;
    assign bus.out_state = out_valid_q ? state_q : '0;
endmodule

// File: tb/tb_photon100_perm.sv
// Self-checking bench for photon100_perm against an array-based PHOTON round model.
module tb_photon100_perm;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    photon100_perm_if bus ();
    photon100_perm_if bus1 ();

    photon100_perm #(.NUM_ROUNDS(12)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    photon100_perm #(.NUM_ROUNDS(1))  u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int vectors     = 0;
    int miscompares = 0;

    int sbox_tbl [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    int rc_tbl   [12] = '{1, 3, 7, 14, 13, 11, 6, 12, 9, 2, 5, 10};
    int ic_tbl   [5]  = '{0, 1, 3, 6, 4};
    int mcs_coef [5]  = '{1, 2, 9, 9, 2};

    // Generic shift-and-add multiply in GF(2^4), reducing by x^4+x+1 (0x13).
    function automatic int gf_mul(input int a, input int b);
        int p = 0;
        for (int k = 0; k < 4; k++) begin
            if ((b & 1) != 0) p = p ^ a;
            b = b >> 1;
            a = a << 1;
            if ((a & 16) != 0) a = a ^ 19;
        end
        return p & 15;
    endfunction

    function automatic logic [99:0] model_perm(input logic [99:0] s, input int nr);
        int m  [5][5];
        int nm [5][5];
        int col[5];
        int t;
        logic [99:0] r;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                m[i][j] = int'((s >> (4 * (24 - 5*i - j))) & 100'hF);
        for (int v = 0; v < nr; v++) begin
            for (int i = 0; i < 5; i++)
                m[i][0] = m[i][0] ^ rc_tbl[v] ^ ic_tbl[i];
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    m[i][j] = sbox_tbl[m[i][j]];
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    nm[i][j] = m[i][(j + i) % 5];
            m = nm;
            for (int j = 0; j < 5; j++) begin
                for (int k = 0; k < 5; k++) col[k] = m[k][j];
                for (int n = 0; n < 5; n++) begin
                    t = 0;
                    for (int k = 0; k < 5; k++) t = t ^ gf_mul(mcs_coef[k], col[k]);
                    for (int k = 0; k < 4; k++) col[k] = col[k+1];
                    col[4] = t;
                end
                for (int k = 0; k < 5; k++) m[k][j] = col[k];
            end
        end
        r = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                r = r | (100'(m[i][j]) << (4 * (24 - 5*i - j)));
        return r;
    endfunction

    function automatic logic [99:0] rand100();
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        return w[99:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [99:0] s);
        int n = 0;
        while (!bus.in_ready && n < 30) begin
            tick();
            n++;
        end
        vectors++;
        if (!bus.in_ready) begin
            miscompares++;
            $display("FAIL start_ready_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
        end
        bus.in_state = s;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input int budget);
        int n = 0;
        while (!bus.out_valid && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (!bus.out_valid) begin
            miscompares++;
            $display("FAIL out_valid_timeout: out_valid=%b after %0d cycles, required 1", bus.out_valid, n);
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_state   = '1;
        bus.out_ready  = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_state  = '0;
        bus1.out_ready = 1'b1;
        tick();
        tick();
        vectors += 5;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        if (bus.out_state !== 100'h0) begin miscompares++; $display("FAIL reset_out_state: got %h expected 0", bus.out_state); end
        if (bus.round_idx !== 4'd0) begin miscompares++; $display("FAIL reset_round_idx: got %0d expected 0", bus.round_idx); end
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_no_accept: busy=%b in_ready=%b expected busy=0 in_ready=1", bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_single_zero();
        logic [99:0] exp_s;
        exp_s = model_perm('0, 12);
        bus.out_ready = 1'b1;
        start('0);
        for (int k = 0; k < 12; k++) begin
            vectors += 3;
            if (bus.round_idx !== 4'(k)) begin miscompares++; $display("FAIL zero_round_idx: got %0d expected %0d", bus.round_idx, k); end
            if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL zero_busy: cycle %0d got %b expected 1", k, bus.busy); end
            if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL zero_early_valid: cycle %0d got %b expected 0", k, bus.out_valid); end
            tick();
        end
        vectors += 4;
        if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL zero_latency: out_valid got %b expected 1", bus.out_valid); end
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy_len: got %b expected 0", bus.busy); end
        if (bus.round_idx !== 4'd0) begin miscompares++; $display("FAIL zero_idx_done: got %0d expected 0", bus.round_idx); end
        if (bus.out_state !== exp_s) begin miscompares++; $display("FAIL zero_out_state: got %h expected %h", bus.out_state, exp_s); end
        tick();
        vectors += 2;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL zero_pulse: out_valid got %b expected 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL zero_back_idle: in_ready got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_one_round();
        logic [99:0] exp_s;
        exp_s = model_perm('0, 1);
        bus1.in_state = '0;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        vectors += 2;
        if (bus1.busy !== 1'b1) begin miscompares++; $display("FAIL one_busy: got %b expected 1", bus1.busy); end
        if (bus1.round_idx !== 4'd0) begin miscompares++; $display("FAIL one_round_idx: got %0d expected 0", bus1.round_idx); end
        tick();
        vectors += 2;
        if (bus1.out_valid !== 1'b1) begin miscompares++; $display("FAIL one_latency: got %b expected 1", bus1.out_valid); end
        if (bus1.out_state !== exp_s) begin miscompares++; $display("FAIL one_out_state: got %h expected %h", bus1.out_state, exp_s); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [99:0] a;
        logic [99:0] exp_s;
        a     = rand100();
        exp_s = model_perm(a, 12);
        bus.out_ready = 1'b0;
        start(a);
        wait_out_valid(20);
        for (int c = 0; c < 5; c++) begin
            vectors += 3;
            if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid: cycle %0d got %b expected 1", c, bus.out_valid); end
            if (bus.out_state !== exp_s) begin miscompares++; $display("FAIL bp_state: cycle %0d got %h expected %h", c, bus.out_state, exp_s); end
            if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: cycle %0d got %b expected 0", c, bus.in_ready); end
            bus.in_valid = (c == 2);
            bus.in_state = rand100();
            tick();
        end
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_state !== exp_s || bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_hold: valid=%b state=%h expected valid=1 state=%h", bus.out_valid, bus.out_state, exp_s);
        end
        bus.out_ready = 1'b1;
        tick();
        vectors += 2;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release: out_valid got %b expected 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_idle: in_ready got %b expected 1", bus.in_ready); end
        tick();
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL bp_pulse_ignored: busy got %b expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        logic [99:0] b;
        logic [99:0] exp_s;
        int n    = 0;
        bit seen = 1'b0;
        bus.out_ready = 1'b1;
        start(rand100());
        while (bus.round_idx !== 4'd6 && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (bus.round_idx !== 4'd6) begin miscompares++; $display("FAIL mid_reach6: round_idx got %0d expected 6", bus.round_idx); end
        rst_n = 1'b0;
        tick();
        vectors += 4;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b expected 0", bus.busy); end
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_in_ready: got %b expected 1", bus.in_ready); end
        if (bus.round_idx !== 4'd0) begin miscompares++; $display("FAIL mid_round_idx: got %0d expected 0", bus.round_idx); end
        rst_n = 1'b1;
        for (int c = 0; c < 14; c++) begin
            tick();
            seen = seen | bus.out_valid;
        end
        vectors++;
        if (seen) begin miscompares++; $display("FAIL mid_no_result: out_valid seen=%b expected 0", seen); end
        b     = rand100();
        exp_s = model_perm(b, 12);
        start(b);
        wait_out_valid(20);
        vectors++;
        if (bus.out_state !== exp_s) begin miscompares++; $display("FAIL mid_after_state: got %h expected %h", bus.out_state, exp_s); end
        tick();
    endtask

    task automatic test_random();
        logic [99:0] a;
        logic [99:0] exp_s;
        bus.out_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            a     = rand100();
            exp_s = model_perm(a, 12);
            start(a);
            wait_out_valid(20);
            vectors++;
            if (bus.out_state !== exp_s) begin miscompares++; $display("FAIL random_state[%0d]: got %h expected %h", r, bus.out_state, exp_s); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [99:0] a;
        logic [99:0] b;
        logic [99:0] out_val [2];
        int  acc_cyc [2];
        int  out_cyc [2];
        int  n_acc = 0;
        int  n_out = 0;
        int  long_pulse = 0;
        bit  prev = 1'b0;
        bit  acc_now;
        a = rand100();
        b = rand100();
        bus.out_ready = 1'b1;
        bus.in_state  = a;
        bus.in_valid  = 1'b1;
        for (int c = 1; c <= 60 && n_out < 2; c++) begin
            acc_now = bus.in_valid && bus.in_ready;
            tick();
            if (acc_now && n_acc < 2) begin
                acc_cyc[n_acc] = c;
                n_acc++;
                if (n_acc == 1) bus.in_state = b;
                else            bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                if (prev) long_pulse++;
                else if (n_out < 2) begin
                    out_cyc[n_out] = c;
                    out_val[n_out] = bus.out_state;
                    n_out++;
                end
            end
            prev = bus.out_valid;
        end
        bus.in_valid = 1'b0;
        tick();
        vectors += 3;
        if (n_acc != 2 || n_out != 2) begin
            miscompares++;
            $display("FAIL b2b_counts: acceptances=%0d results=%0d expected 2 and 2", n_acc, n_out);
        end
        if (long_pulse != 0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_pulse_len: extra valid cycles=%0d trailing=%b expected 0 and 0", long_pulse, bus.out_valid);
        end
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_idle: in_ready got %b expected 1", bus.in_ready); end
        if (n_acc == 2 && n_out == 2) begin
            vectors += 4;
            if (acc_cyc[1] - acc_cyc[0] != 14) begin miscompares++; $display("FAIL b2b_interval: got %0d expected 14", acc_cyc[1] - acc_cyc[0]); end
            if (out_cyc[0] - acc_cyc[0] != 12) begin miscompares++; $display("FAIL b2b_latency: got %0d expected 12", out_cyc[0] - acc_cyc[0]); end
            if (out_val[0] !== model_perm(a, 12)) begin miscompares++; $display("FAIL b2b_first: got %h expected %h", out_val[0], model_perm(a, 12)); end
            if (out_val[1] !== model_perm(b, 12)) begin miscompares++; $display("FAIL b2b_second: got %h expected %h", out_val[1], model_perm(b, 12)); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_zero();
        test_one_round();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/photon100_perm.md
Name: photon100_perm

Overview:
- Iterative PHOTON-80/20/16 permutation core, 100-bit state: 5x5 matrix of 4-bit cells, 12 rounds, one round per clock.
- Sits upstream of the AddConstants datapath. It owns the state register and round counter, and drives the round index (v) and state into the round function.
- The round function is AddConstants, then SubCells, then ShiftRows, then MixColumnsSerial.
- Valid/ready handshake on both input and output. Sits between the sponge absorb/squeeze controller and the permutation datapath.

Parameters:
NUM_ROUNDS, 12, rounds per permutation; legal range 1..12; indexes RC[0..NUM_ROUNDS-1].

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  in_state is valid
in_ready  output  1  core accepts a new state
in_state  input  100  state to permute
out_valid  output  1  out_state holds a finished result
out_ready  input  1  consumer takes the result
out_state  output  100  permuted state
busy  output  1  high while rounds are executing
round_idx  output  4  current round number (v) applied this cycle

Behaviour:
- Cell mapping: cell (i,j), row i 0..4, column j 0..4, occupies bits [(25-5i-j)*4-1 : (25-5i-j)*4-4]. Cell (0,0) is [99:96]; cell (4,4) is [3:0]. The same mapping applies to in_state and out_state.
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; state register and round counter go to 0.
  - Outputs: in_ready=1, out_valid=0, busy=0, out_state=0, round_idx=0.
  - Reset wins over every other event, including mid-RUN and in DONE; any in-flight result is discarded.
- FSM, states IDLE, RUN, DONE:
  - IDLE: in_ready=1. If in_valid=1, the state register loads in_state, rnd=0, and the FSM goes to RUN.
  - RUN: in_ready=0, busy=1, round_idx=rnd. Each edge: state <= R(state, rnd).
    - If rnd==NUM_ROUNDS-1, go to DONE; otherwise rnd <= rnd+1.
  - DONE: out_valid=1, out_state=state register, busy=0, in_ready=0. If out_ready=1, go to IDLE and clear rnd. in_valid is ignored.
- Latency and throughput:
  - Acceptance edge E0; rounds execute on edges E1..E_NUM_ROUNDS.
  - out_valid is high after edge E_NUM_ROUNDS, i.e. 12 cycles after acceptance by default.
  - Minimum initiation interval is NUM_ROUNDS+2 cycles (14 by default).
- out_state and out_valid stay stable while out_valid=1 and out_ready=0, for any number of cycles.
- round_idx=0 outside RUN.
- Round R(s, v):
  - AddConstants: for i=0..4, cell(i,0) ^= RC[v] ^ IC[i].
    - RC = 1,3,7,E,D,B,6,C,9,2,5,A.
    - IC = 0,1,3,6,4.
    - Cells with j!=0 are unchanged. All five rows are processed.
  - SubCells: every cell goes through the PRESENT S-box: 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  - ShiftRows: new cell(i,j) = old cell(i,(j+i) mod 5). Row 0 is unchanged; row 4 rotates left by 4.
  - MixColumnsSerial, applied per column, repeated 5 times:
    - t = 1*c0 ^ 2*c1 ^ 9*c2 ^ 9*c3 ^ 2*c4, where c0..c4 are rows 0..4 of the column.
    - Then (c0..c4) <= (c1,c2,c3,c4,t).
    - Multiplication is in GF(2^4) with polynomial x^4+x+1.
  - The whole round is combinational within one cycle; there is no internal pipelining.
- Simultaneous events:
  - in_valid in RUN or DONE is not accepted; in_ready=0, and the upstream must hold its data.
  - out_ready while out_valid=0 has no effect.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with in_valid=1 and in_state=all-F -> in_ready=1, out_valid=0, busy=0, out_state=0, and nothing is accepted.
2. Single permutation of all-zero in_state, out_ready=1:
   - round_idx reads 0,1,...,11 on consecutive cycles.
   - busy is high for exactly 12 cycles.
   - out_valid rises 12 cycles after acceptance.
   - out_state matches the bit-exact golden model (AC/SC/SR/MCS as above).
3. NUM_ROUNDS=1, all-zero input -> after AC, column-0 cells are 1,0,2,7,5. After SC, column-0 cells are 5,C,6,D,0 and all other cells are C. Final output matches the model after ShiftRows and MCS.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_state stable, in_ready=0, and a pulsed in_valid is ignored. On the out_ready=1 edge the core returns to IDLE, and in_ready=1 on the next cycle.
5. Reset mid-operation: assert rst_n=0 when round_idx=6 -> next cycle is IDLE with out_valid=0 and no result emitted. A new random state then completes and matches the model.
6. Back-to-back: in_valid held 1 with two random states, out_ready tied 1 -> acceptances 14 cycles apart, two out_valid pulses each 1 cycle long, both results match the model.
